// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM state encoding and
// the mul/div opcode classifier.
// Optional feature macro: ITER_ALU_SIGNED_MULDIV_EN (adds signed MULT/DIV).
package iter_alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True for opcodes handled by the iterative engine.
    function automatic logic is_muldiv(input logic [3:0] op);
`ifdef ITER_ALU_SIGNED_MULDIV_EN
        return (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MULT) || (op == OP_DIV);
`else
        return (op == OP_MULTU) || (op == OP_DIVU);
`endif
    endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Request/result bundle between the execute-stage control and iter_alu.
//
// Handshake: a request is taken on the rising clk edge where start && in_ready;
// ALU_control/src_A/src_B are sampled on that edge only. start while in_ready
// is low is dropped (no queuing). out_valid is a one-cycle pulse and
// ALU_result/zero/overflow/hi/lo are valid in that cycle and then held.
interface iter_alu_if #(parameter int WIDTH = 32);
    import iter_alu_pkg::*;

    logic             start;
    logic             in_ready;
    logic [3:0]       ALU_control;
    logic [WIDTH-1:0] src_A;
    logic [WIDTH-1:0] src_B;
    logic             out_valid;
    logic [WIDTH-1:0] ALU_result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    state_t           dbg_state;

    modport master (
        output start, ALU_control, src_A, src_B,
        input  in_ready, out_valid, ALU_result, zero, overflow, hi, lo, busy, dbg_state
    );

    modport slave (
        input  start, ALU_control, src_A, src_B,
        output in_ready, out_valid, ALU_result, zero, overflow, hi, lo, busy, dbg_state
    );

endinterface

// File: rtl/iter_muldiv.sv
// Iterative one-bit-per-cycle multiply (shift-add) and divide (restoring
// shift-subtract). acc holds the product upper half / remainder, q holds the
// product lower half / quotient. With ITER_ALU_SIGNED_MULDIV_EN the engine
// iterates on magnitudes and applies a sign fix-up on the result outputs.
module iter_muldiv
    import iter_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             is_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] q_n;

`ifdef ITER_ALU_SIGNED_MULDIV_EN
    logic neg_prod_q;
    logic neg_quo_q;
    logic neg_rem_q;
    logic is_signed;
`endif

    // Operand conditioning at load: magnitudes for signed ops, raw otherwise.
    always_comb begin
        a_mag  = a;
        b_mag  = b;
        is_div = (op == OP_DIVU);
`ifdef ITER_ALU_SIGNED_MULDIV_EN
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        if (op == OP_DIV) is_div = 1'b1;
        if (is_signed && a[WIDTH-1]) a_mag = -a;
        if (is_signed && b[WIDTH-1]) b_mag = -b;
`endif
    end

    // One iteration step for multiply or divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, d_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, q_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, d_q};
        if (div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_n = div_diff[WIDTH-1:0];
                q_n   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = div_shift[WIDTH-1:0];
                q_n   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = mul_sum[WIDTH:1];
            q_n   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
    end

    // Engine registers: load clears accumulator and counter, step advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc_q <= '0;
            q_q   <= a_mag;
            d_q   <= b_mag;
            cnt_q <= '0;
            div_q <= is_div;
        end else if (step) begin
            acc_q <= acc_n;
            q_q   <= q_n;
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef ITER_ALU_SIGNED_MULDIV_EN
    // Sign fix-up flags; a zero divisor keeps the all-ones quotient as is.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_prod_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (load) begin
            neg_prod_q <= (op == OP_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_quo_q  <= (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
            neg_rem_q  <= (op == OP_DIV) && a[WIDTH-1];
        end
    end
`endif

    // Final step flag: asserted during the WIDTH-th step.
    assign done = step && (cnt_q == CNT_W'(WIDTH - 1));

    // Result presentation, with sign correction when enabled.
    always_comb begin
        res_hi = acc_q;
        res_lo = q_q;
`ifdef ITER_ALU_SIGNED_MULDIV_EN
        if (neg_prod_q) {res_hi, res_lo} = -{acc_q, q_q};
        if (neg_quo_q)  res_lo = -q_q;
        if (neg_rem_q)  res_hi = -acc_q;
`endif
    end

endmodule

// File: rtl/iter_alu.sv
// Execute-stage ALU with registered single-cycle ops and an iterative
// multiply/divide engine writing HI/LO.
// Optional feature macro: ITER_ALU_SIGNED_MULDIV_EN (opcodes 1010 MULT, 1011 DIV);
// without it those opcodes fall through to ADD.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    iter_alu_if.slave   bus
);

    state_t           state_q;
    state_t           state_n;
    logic             in_ready;
    logic             busy;
    logic             accept;
    logic             accept_md;
    logic             accept_sc;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    assign accept    = bus.start && in_ready;
    assign accept_md = accept && is_muldiv(bus.ALU_control);
    assign accept_sc = accept && !is_muldiv(bus.ALU_control);

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .load   (accept_md),
        .step   (state_q == S_RUN),
        .op     (bus.ALU_control),
        .a      (bus.src_A),
        .b      (bus.src_B),
        .done   (eng_done),
        .res_hi (eng_hi),
        .res_lo (eng_lo)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_n;
    end

    // FSM next-state: single-cycle ops never leave IDLE.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (accept_md) state_n = S_RUN;
            S_RUN:   if (eng_done)  state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, busy through RUN and DONE.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_RUN:   busy     = 1'b1;
            S_DONE:  busy     = 1'b1;
            default: ;
        endcase
    end

    // Single-cycle datapath; unlisted opcodes behave as ADD.
    always_comb begin
        sum     = bus.src_A + bus.src_B;
        diff    = bus.src_A - bus.src_B;
        alu_res = sum;
        alu_ovf = (bus.src_A[WIDTH-1] == bus.src_B[WIDTH-1]) && (sum[WIDTH-1] != bus.src_A[WIDTH-1]);
        case (bus.ALU_control)
            OP_AND: begin alu_res = bus.src_A & bus.src_B;    alu_ovf = 1'b0; end
            OP_OR:  begin alu_res = bus.src_A | bus.src_B;    alu_ovf = 1'b0; end
            OP_XOR: begin alu_res = bus.src_A ^ bus.src_B;    alu_ovf = 1'b0; end
            OP_NOR: begin alu_res = ~(bus.src_A | bus.src_B); alu_ovf = 1'b0; end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.src_A[WIDTH-1] != bus.src_B[WIDTH-1]) && (diff[WIDTH-1] != bus.src_A[WIDTH-1]);
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_A) < $signed(bus.src_B))};
                alu_ovf = 1'b0;
            end
            OP_SLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, (bus.src_A < bus.src_B)};
                alu_ovf = 1'b0;
            end
            default: ;
        endcase
    end

    // Output registers: single-cycle results on accept, HI/LO only from DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept_sc) begin
                result_q    <= alu_res;
                zero_q      <= (alu_res == '0);
                overflow_q  <= alu_ovf;
                out_valid_q <= 1'b1;
            end else if (state_q == S_DONE) begin
                hi_q        <= eng_hi;
                lo_q        <= eng_lo;
                result_q    <= eng_lo;
                zero_q      <= (eng_lo == '0);
                overflow_q  <= 1'b0;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.busy       = busy;
    assign bus.dbg_state  = state_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.ALU_result = result_q;
    assign bus.zero       = zero_q;
    assign bus.overflow   = overflow_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Single-cycle logic and arithmetic ops have a registered result.
- Adds iterative unsigned multiply and divide, one bit per cycle, with HI/LO result registers.
- Sits in the execute stage; the control FSM stalls on in_ready low.

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; the op is accepted on a clk edge where start && in_ready.
in_ready  out  1  high when idle (= !busy).
ALU_control  in  4  opcode, sampled at accept.
src_A  in  WIDTH  operand A, sampled at accept.
src_B  in  WIDTH  operand B, sampled at accept.
out_valid  out  1  one-cycle pulse; result, zero, hi and lo are valid in that cycle.
ALU_result  out  WIDTH  registered result; held until the next completion.
zero  out  1  registered; equals (ALU_result == 0), updated with out_valid.
overflow  out  1  signed overflow of ADD/SUB; 0 for all other ops.
hi  out  WIDTH  HI register (product upper / remainder).
lo  out  WIDTH  LO register (product lower / quotient).
busy  out  1  high while a mul/div iterates.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR (A|B); 0010 ADD; 0110 SUB.
  - 0111 SLT, signed: result 1 if $signed(A)<$signed(B), else 0.
  - 0011 XOR; 0100 NOR; 0101 SLTU (unsigned compare).
  - 1000 MULTU; 1001 DIVU.
  - Every other code behaves as ADD.
- Reset: all outputs 0 except in_ready=1; state IDLE; counter 0. Reset mid-operation aborts the op with no out_valid, and hi/lo are cleared.
- States:
  - IDLE: in_ready=1. Accepting a single-cycle op registers the result and pulses out_valid in the next cycle (latency 1); the state stays IDLE. Accepting MULTU/DIVU latches operands, clears the accumulator and counter, and moves to RUN.
  - RUN: busy=1, in_ready=0. One shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle. After WIDTH steps, moves to DONE.
  - DONE: writes hi/lo and ALU_result=lo, pulses out_valid, moves to IDLE. Mul/div latency is WIDTH+1 cycles from accept to out_valid.
- start while busy is ignored; no queuing.
- A back-to-back start is legal in the cycle out_valid pulses, because in_ready is high in DONE's successor IDLE cycle. in_ready is 0 during DONE itself.
- Arithmetic is modulo 2^WIDTH. overflow = operand signs equal and result sign differs (ADD), or operand signs differ and result sign differs from A (SUB).
- MULTU: {hi,lo} = A*B, full 2*WIDTH product.
- DIVU by zero: lo = all ones, hi = src_A, same latency, no error flag.
- hi/lo change only on MULTU/DIVU completion; single-cycle ops leave them untouched.

Optional Feature:
- Macro ITER_ALU_SIGNED_MULDIV_EN.
- Defined:
  - Opcode 1010 MULT: signed, {hi,lo} two's complement product.
  - Opcode 1011 DIV: signed. The quotient truncates toward zero; the remainder takes the sign of the dividend. Implemented by magnitude iteration plus sign fix-up in DONE, so latency stays WIDTH+1.
  - Signed DIV by zero: lo = all ones, hi = src_A.
  - Signed DIV of most-negative by -1: lo = most-negative, hi = 0.
- Undefined: 1010/1011 behave as ADD (single-cycle).

Decomposition:
- Package iter_alu_pkg:
  - opcode localparams (OP_AND … OP_DIV);
  - state encoding (S_IDLE, S_RUN, S_DONE);
  - helper function is_muldiv(op).
- Sub-module iter_muldiv holds the iterative engine: operand/accumulator registers, counter, step logic, done flag.
- iter_alu holds opcode decode, the single-cycle datapath, the FSM handshake and the output registers.

Test Plan:
- WIDTH=32, start with ADD 0x7FFFFFFF+0x00000001 -> next cycle out_valid=1, ALU_result=0x80000000, overflow=1, zero=0.
- SUB 5-5 then SLT 0xFFFFFFFF,0x00000001 on consecutive cycles -> two pulses: result 0 with zero=1, then result 1; SLTU of the same operands -> 0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> in_ready low 33 cycles; out_valid 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001. A start pulsed mid-run is ignored.
- DIVU 100/7 -> lo=14, hi=2. DIVU 9/0 -> lo=0xFFFFFFFF, hi=9. Both have latency 33.
- Reset asserted 10 cycles into a MULTU -> no out_valid; next cycle in_ready=1, hi=lo=0, ALU_result=0. A following AND 0xF0F0,0x0FF0 -> 0x00F0.
- With ITER_ALU_SIGNED_MULDIV_EN: DIV -7/2 -> lo=-3, hi=-1; MULT -3*4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4. Without the macro, opcode 1010 with 3,4 -> result 7 in 1 cycle.
